// File: rtl/demux1_8.sv
// 1-to-8 word demultiplexer: collects eight WIDTH-bit words into registered slots
// (auto-increment or addressed), then presents them as one stable bundle.

module demux1_8_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clear)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

module demux1_8 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             mode,
    input  logic [2:0]       selector,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] output1,
    output logic [WIDTH-1:0] output2,
    output logic [WIDTH-1:0] output3,
    output logic [WIDTH-1:0] output4,
    output logic [WIDTH-1:0] output5,
    output logic [WIDTH-1:0] output6,
    output logic [WIDTH-1:0] output7,
    output logic [WIDTH-1:0] output8,
    output logic [7:0]       slot_mask,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NUM_SLOTS = 8;

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_FULL = 1'b1;

    typedef struct packed {
        logic [2:0]       target;
        logic [WIDTH-1:0] data;
    } req_t;

    logic [0:0]                            state;
    logic [2:0]                            ptr;
    logic [NUM_SLOTS-1:0]                  mask;
    logic [NUM_SLOTS-1:0][WIDTH-1:0]       slot;
    logic [NUM_SLOTS-1:0]                  hit;
    logic [NUM_SLOTS-1:0]                  mask_set;
    logic                                  accept;
    req_t                                  req;

    // Handshake flags come straight from the state register, never from inputs.
    assign in_ready = (state == S_FILL);
    assign out_valid = (state == S_FULL);
    assign slot_mask = mask;

    assign accept     = in_valid & in_ready;
    assign req.target = mode ? selector : ptr;
    assign req.data   = in_data;
    assign hit        = NUM_SLOTS'(1) << req.target;
    assign mask_set   = mask | hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FILL;
            ptr   <= 3'd0;
            mask  <= '0;
        end else if (clear) begin
            state <= S_FILL;
            ptr   <= 3'd0;
            mask  <= '0;
        end else begin
            case (state)
                S_FILL: begin
                    if (accept) begin
                        mask <= mask_set;
                        // Pointer only advances on auto-mode accepts; wraps naturally at 3 bits.
                        if (!mode)
                            ptr <= ptr + 3'd1;
                        if (&mask_set)
                            state <= S_FULL;
                    end
                end
                S_FULL: begin
                    // Release frees the mask and pointer but keeps the slot data.
                    if (out_ready) begin
                        state <= S_FILL;
                        ptr   <= 3'd0;
                        mask  <= '0;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        demux1_8_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (clear),
            .load  (accept & hit[i]),
            .d     (req.data),
            .q     (slot[i])
        );
    end

    assign output1 = slot[0];
    assign output2 = slot[1];
    assign output3 = slot[2];
    assign output4 = slot[3];
    assign output5 = slot[4];
    assign output6 = slot[5];
    assign output7 = slot[6];
    assign output8 = slot[7];

endmodule

// File: tb/tb_demux1_8.sv
// Self-checking bench for demux1_8: vector table, directed corner sequences and
// randomized traffic against a slot-array reference model.

module tb_demux1_8;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             mode;
    logic [2:0]       selector;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] o1, o2, o3, o4, o5, o6, o7, o8;
    logic [7:0]       slot_mask;
    logic             out_valid;
    logic             out_ready;

    demux1_8 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .mode      (mode),
        .selector  (selector),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .output1   (o1),
        .output2   (o2),
        .output3   (o3),
        .output4   (o4),
        .output5   (o5),
        .output6   (o6),
        .output7   (o7),
        .output8   (o8),
        .slot_mask (slot_mask),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: slot contents, written flags, auto pointer, full flag.
    logic [WIDTH-1:0] m_slot [8];
    bit               m_wr   [8];
    int               m_ptr;
    bit               m_full;

    typedef struct {
        logic             clr;
        logic             md;
        logic [2:0]       sel;
        logic [WIDTH-1:0] data;
        logic             vld;
        logic             ordy;
        logic [7:0]       exp_mask;
        logic             exp_irdy;
        logic             exp_ovld;
    } vec_t;

    vec_t tbl [14];

    function automatic logic [WIDTH-1:0] dut_slot(int i);
        case (i)
            0: return o1;
            1: return o2;
            2: return o3;
            3: return o4;
            4: return o5;
            5: return o6;
            6: return o7;
            default: return o8;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_slot[i] = '0;
            m_wr[i]   = 1'b0;
        end
        m_ptr  = 0;
        m_full = 1'b0;
    endtask

    task automatic model_edge(logic clr, logic md, logic [2:0] sel, logic [WIDTH-1:0] data,
                              logic vld, logic ordy);
        int t;
        int cnt;
        if (clr) begin
            model_reset();
        end else if (m_full) begin
            if (ordy) begin
                for (int i = 0; i < 8; i++) m_wr[i] = 1'b0;
                m_ptr  = 0;
                m_full = 1'b0;
            end
        end else if (vld) begin
            t = md ? int'(sel) : m_ptr;
            m_slot[t] = data;
            m_wr[t]   = 1'b1;
            if (!md) m_ptr = (m_ptr + 1) % 8;
            cnt = 0;
            for (int i = 0; i < 8; i++) cnt += int'(m_wr[i]);
            if (cnt == 8) m_full = 1'b1;
        end
    endtask

    task automatic check_model(string tag);
        logic [7:0] em;
        for (int i = 0; i < 8; i++) em[i] = m_wr[i];
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_slot%0d", tag, i), 32'(dut_slot(i)), 32'(m_slot[i]));
        chk({tag, "_mask"}, 32'(slot_mask), 32'(em));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(!m_full));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_full));
    endtask

    // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic cyc(logic clr, logic md, logic [2:0] sel, logic [WIDTH-1:0] data,
                       logic vld, logic ordy, string tag);
        clear = clr; mode = md; selector = sel; in_data = data; in_valid = vld; out_ready = ordy;
        model_edge(clr, md, sel, data, vld, ordy);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; mode = 1'b0; selector = 3'd0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        model_reset();

        // Vector table: 8 auto fills, 5 held FULL cycles with junk input, then release.
        for (int k = 0; k < 8; k++)
            tbl[k] = '{1'b0, 1'b0, 3'd0, 16'((k + 1) * 16'h1111), 1'b1, 1'b0,
                       8'((9'd1 << (k + 1)) - 9'd1), (k < 7), (k == 7)};
        for (int k = 8; k < 13; k++)
            tbl[k] = '{1'b0, 1'b0, 3'd0, 16'hDEAD, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 3'd0, 16'hDEAD, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

        #7;
        check_model("rst_low");
        #5 rst_n = 1'b1;
        #1 check_model("rst_rel");

        for (int k = 0; k < 14; k++) begin
            cyc(tbl[k].clr, tbl[k].md, tbl[k].sel, tbl[k].data, tbl[k].vld, tbl[k].ordy,
                $sformatf("tbl%0d", k));
            chk($sformatf("tbl%0d_exp_mask", k), 32'(slot_mask), 32'(tbl[k].exp_mask));
            chk($sformatf("tbl%0d_exp_irdy", k), 32'(in_ready), 32'(tbl[k].exp_irdy));
            chk($sformatf("tbl%0d_exp_ovld", k), 32'(out_valid), 32'(tbl[k].exp_ovld));
        end
        for (int i = 0; i < 8; i++)
            chk($sformatf("retain_slot%0d", i), 32'(dut_slot(i)), 32'((i + 1) * 16'h1111));

        // Addressed mode with overwrite of slot 7.
        for (int k = 0; k < 9; k++) begin
            logic [2:0] s;
            s = (k < 2) ? 3'd7 : 3'(k - 2);
            cyc(1'b0, 1'b1, s, 16'hA000 + 16'(k), 1'b1, 1'b0, $sformatf("addr%0d", k));
            chk($sformatf("addr%0d_ovld", k), 32'(out_valid), 32'(k == 8));
        end
        chk("addr_overwrite", 32'(o8), 32'h0000_A001);
        chk("addr_slot0", 32'(o1), 32'h0000_A002);
        cyc(1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b1, "addr_release");

        // Mixed modes: addressed write must not move the auto pointer.
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b0, 3'd6, 16'hB000 + 16'(k), 1'b1, 1'b0, $sformatf("mix%0d", k));
        cyc(1'b0, 1'b1, 3'd5, 16'hB055, 1'b1, 1'b0, "mix_addr");
        cyc(1'b0, 1'b0, 3'd0, 16'hB003, 1'b1, 1'b0, "mix_auto");
        chk("mix_ptr3", 32'(o4), 32'h0000_B003);
        chk("mix_mask", 32'(slot_mask), 32'h0000_002F);

        // Clear coinciding with the final accept.
        cyc(1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0, "pre_clear");
        for (int k = 0; k < 7; k++)
            cyc(1'b0, 1'b0, 3'd0, 16'hC000 + 16'(k), 1'b1, 1'b0, $sformatf("cf%0d", k));
        cyc(1'b1, 1'b0, 3'd0, 16'hC007, 1'b1, 1'b0, "clr_vs_accept");
        chk("clr_mask", 32'(slot_mask), 32'h0);
        chk("clr_ovld", 32'(out_valid), 32'h0);
        chk("clr_o8", 32'(o8), 32'h0);

        // Asynchronous reset mid-collection.
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 1'b0, 3'd0, 16'hD000 + 16'(k), 1'b1, 1'b0, $sformatf("ar%0d", k));
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_model("async_rst");
        #2 rst_n = 1'b1;
        cyc(1'b0, 1'b0, 3'd0, 16'h5555, 1'b1, 1'b0, "post_rst");
        chk("post_rst_o1", 32'(o1), 32'h0000_5555);
        chk("post_rst_mask", 32'(slot_mask), 32'h1);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 29) == 0), 1'($urandom), 3'($urandom), 16'($urandom),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
